alu_arbiter: RTL and testbench

- Shares one registered ALU (AND/OR/ADD/SUB, 1-cycle registered result plus zero flag) among NUM_REQ requesters, such as the branch-compare unit and the address-generation unit.
- Grants requesters round-robin and accepts one operation at a time with a valid/ready handshake.
- Drives the ALU inputs, captures the result and zero flag, and returns them to the granted requester with a valid/ready response.

---
 rtl/alu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU among NUM_REQ requesters.
//
// Requesters are granted one at a time with a valid/ready handshake. The granted operation is
// driven onto the ALU inputs, the registered ALU result and zero flag are captured, and both are
// returned to the granted requester through a one-hot valid/ready response.
//
// ALU_ctrl_t encoding used by requesters and the ALU: 0 AND, 1 OR, 2 ADD, 3 SUB.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> lowest-index valid requester wins (no RR pointer)
//                          undefined -> round-robin starting after the last winner
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         synchronous reset, active-low
//   req_valid   per-requester operation request
//   req_ready   one-hot accept strobe (combinational, IDLE only)
//   req_op      per-requester ALU op, slice i = requester i
//   req_a/b     per-requester operands
//   resp_valid  one-hot result valid
//   resp_ready  per-requester result accept
//   resp_data   captured result
//   resp_zero   captured zero flag
//   alu_a/b     ALU operand inputs
//   alu_ctrl    ALU op select
//   alu_result  ALU registered result
//   alu_zero    ALU registered zero flag
//   busy        high whenever the FSM is not idle
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned OP_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_zero,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  output logic                      busy
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

  state_e          state_q;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] win;
  logic            found;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Lowest index wins; higher indices may starve.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[IdxW'(k)]) begin
        found = 1'b1;
        win   = IdxW'(k);
      end
    end
  end
`else
  // Last winner; reset value NUM_REQ-1 makes requester 0 first after reset.
  logic [IdxW-1:0] ptr_q;

  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] p, input int unsigned k);
    int unsigned s;
    s = (32'(p) + k) % NUM_REQ;
    return IdxW'(s);
  endfunction

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        win   = rr_idx(ptr_q, k);
      end
    end
  end
`endif

  always_comb begin
    sel_op = req_op[OP_W*32'(win) +: OP_W];
    sel_a  = req_a[DATA_W*32'(win) +: DATA_W];
    sel_b  = req_b[DATA_W*32'(win) +: DATA_W];
  end

  // Accept strobe is suppressed while reset is being sampled.
  always_comb begin
    req_ready = '0;
    if (rst && (state_q == StIdle) && found) begin
      req_ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_valid <= '0;
      busy       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      ptr_q      <= IdxW'(NUM_REQ - 1);
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            alu_ctrl <= sel_op;
            alu_a    <= sel_a;
            alu_b    <= sel_b;
            grant_q  <= win;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr_q    <= win;
`endif
            busy     <= 1'b1;
            state_q  <= StExec;
          end
        end
        // ALU registers its result at the end of this cycle.
        StExec: state_q <= StCapt;
        StCapt: begin
          resp_data  <= alu_result;
          resp_zero  <= alu_zero;
          resp_valid <= NUM_REQ'(1) << grant_q;
          state_q    <= StResp;
        end
        StResp: begin
          // Only the granted requester's resp_ready matters.
          if (resp_ready[grant_q]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam logic [1:0] OpAnd = 2'd0;
  localparam logic [1:0] OpOr  = 2'd1;
  localparam logic [1:0] OpAdd = 2'd2;
  localparam logic [1:0] OpSub = 2'd3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [7:0]   req_op = '0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready = '0;
  logic [31:0]  resp_data;
  logic         resp_zero;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [1:0]   alu_ctrl;
  logic [31:0]  alu_result = '0;
  logic         alu_zero = 1'b0;
  logic         busy;

  alu_arbiter #(
    .NUM_REQ(4),
    .DATA_W (32),
    .OP_W   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_zero (resp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Registered ALU model.
  function automatic logic [31:0] alu_f(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpAdd:   return a + b;
      default: return a - b;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_result <= alu_f(alu_ctrl, alu_a, alu_b);
    alu_zero   <= (alu_f(alu_ctrl, alu_a, alu_b) == 32'd0);
  end

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        zero;
  } resp_t;

  resp_t exp_resp[$];
  int    exp_grant[$];
  int    checks = 0;
  int    passed = 0;
  int    grant_cnt = 0;
  int    last_grant = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Monitor: grants and response handshakes checked against the scoreboard queues.
  always @(negedge clk) begin
    int    g;
    int    r;
    resp_t e;
    if (rst) begin
      if ((req_valid & req_ready) != 4'b0) begin
        g = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        chk("grant_onehot", 32'($countones(req_ready)), 32'd1);
        if (exp_grant.size() == 0) chk("grant_unexpected", 32'(g), 32'd99);
        else chk("grant_order", 32'(g), 32'(exp_grant.pop_front()));
        grant_cnt++;
        last_grant = g;
      end
      if ((resp_valid & resp_ready) != 4'b0) begin
        r = -1;
        for (int i = 0; i < 4; i++) if (resp_valid[i]) r = i;
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", 32'(r), 32'd99);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_idx", 32'(r), 32'(e.idx));
          chk("resp_data", resp_data, e.data);
          chk("resp_zero", 32'(resp_zero), 32'(e.zero));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*2 +: 2]  = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic push(input int i, input logic [31:0] d, input logic z);
    resp_t e;
    e.idx  = i;
    e.data = d;
    e.zero = z;
    exp_resp.push_back(e);
    exp_grant.push_back(i);
  endtask

  // Returns #1 after the accept edge of the target-th grant.
  task automatic run_grants(input int target, input bit clr);
    int last;
    last = grant_cnt;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (grant_cnt != last) begin
        last = grant_cnt;
        if (clr) req_valid[last_grant] = 1'b0;
      end
      if (grant_cnt >= target) return;
    end
    chk("grant_timeout", 32'(grant_cnt), 32'(target));
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_resp.size() == 0) return;
    end
    chk("idle_timeout", 32'(exp_resp.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, with every requester asserting valid.
    rst       = 1'b0;
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_zero", 32'(resp_zero), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid  = '0;
    rst        = 1'b1;
    resp_ready = 4'hF;

    // Single ADD 5 + -5 with latency checks.
    push(0, 32'd0, 1'b1);
    set_req(0, OpAdd, 32'd5, 32'hFFFF_FFFB);
    run_grants(grant_cnt + 1, 1'b1);
    chk("t1_exec_busy", 32'(busy), 32'd1);
    chk("t1_exec_nresp", 32'(resp_valid), 32'd0);
    chk("t1_exec_ready", 32'(req_ready), 32'd0);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_ctrl", 32'(alu_ctrl), 32'(OpAdd));
    @(posedge clk);
    #1;
    chk("t1_capt_nresp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_resp_valid", 32'(resp_valid), 32'b0001);
    wait_idle();
    chk("t1_resp_cleared", 32'(resp_valid), 32'd0);

`ifndef ALU_ARB_FIXED_PRIO_EN
    // All four held valid: round-robin 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, OpSub, 32'(i + 10), 32'd1);
    for (int i = 0; i < 4; i++) push(i, 32'(i + 9), 1'b0);
    push(0, 32'd9, 1'b0);
    run_grants(grant_cnt + 5, 1'b0);
    req_valid = '0;
    wait_idle();
    chk("t2_hold_alu_a", alu_a, 32'd10);
    chk("t2_hold_alu_b", alu_b, 32'd1);
    chk("t2_hold_alu_ctrl", 32'(alu_ctrl), 32'(OpSub));
`else
    // Fixed priority: req0 wins while valid, req3 only once req0 drops.
    do_reset();
    set_req(0, OpAdd, 32'd0, 32'd0);
    set_req(3, OpOr, 32'd8, 32'd0);
    for (int i = 0; i < 3; i++) push(0, 32'd0, 1'b1);
    push(3, 32'd8, 1'b0);
    run_grants(grant_cnt + 3, 1'b0);
    req_valid[0] = 1'b0;
    run_grants(grant_cnt + 1, 1'b1);
    wait_idle();
`endif

    // Response back-pressure on req2, with req1 waiting behind it.
    resp_ready = '0;
    push(2, 32'd0, 1'b1);
    set_req(2, OpAnd, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    run_grants(grant_cnt + 1, 1'b1);
    set_req(1, OpOr, 32'd1, 32'd4);
    push(1, 32'd5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(resp_valid), 32'b0100);
      chk("bp_data", resp_data, 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      resp_ready = (k == 2) ? 4'b1011 : 4'b0000;
      @(posedge clk);
      #1;
    end
    resp_ready = 4'hF;
    run_grants(grant_cnt + 1, 1'b1);
    wait_idle();

    // Reset while in EXEC drops the operation.
    set_req(0, OpAdd, 32'd1, 32'd1);
    exp_grant.push_back(0);
    run_grants(grant_cnt + 1, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_alu_a", alu_a, 32'd0);
    chk("rx_alu_b", alu_b, 32'd0);
    chk("rx_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rx_resp_data", resp_data, 32'd0);
    chk("rx_resp_valid", 32'(resp_valid), 32'd0);
    chk("rx_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rx_no_resp", 32'(resp_valid), 32'd0);
    chk("rx_idle", 32'(busy), 32'd0);
    push(3, 32'd3, 1'b0);
    set_req(3, OpOr, 32'd1, 32'd2);
    run_grants(grant_cnt + 1, 1'b1);
    wait_idle();
    do_reset();
    set_req(0, OpAdd, 32'd2, 32'd3);
    set_req(3, OpOr, 32'd1, 32'd2);
    push(0, 32'd5, 1'b0);
    push(3, 32'd3, 1'b0);
    run_grants(grant_cnt + 2, 1'b1);
    wait_idle();

    // Overflow wrap, with resp_ready pulses on non-granted requesters.
    resp_ready = 4'b1101;
    push(1, 32'h8000_0000, 1'b0);
    set_req(1, OpAdd, 32'h7FFF_FFFF, 32'd1);
    run_grants(grant_cnt + 1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("ov_valid", 32'(resp_valid), 32'b0010);
    resp_ready = 4'b0000;
    @(posedge clk);
    #1;
    chk("ov_hold_valid", 32'(resp_valid), 32'b0010);
    resp_ready = 4'b1101;
    @(posedge clk);
    #1;
    chk("ov_hold_busy", 32'(busy), 32'd1);
    chk("ov_hold_data", resp_data, 32'h8000_0000);
    resp_ready = 4'hF;
    wait_idle();

    chk("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
